pipe_rx_detect_seq: RTL and testbench

Sequences PCIe Detect-state receiver detection on the PIPE interface for up to 16 lanes. On a start request from the main LTSSM it drives the Detect.Quiet wait, issues TxDetectRx_Loopback with lanes held in P1, collects per-lane PhyStatus/RxStatus responses with a timeout, and reports the detected-lane mask and count back to the LTSSM. It sits between the LTSSM and the PIPE command/status signals, alongside the TX lane datapath.

---
 rtl/pipe_rx_detect_seq.sv | 233 +++++++++++++++++++++++
 tb/tb_pipe_rx_detect_seq.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/pipe_rx_detect_seq.sv
// pipe_rx_detect_seq: PCIe Detect-state receiver detection sequencer on PIPE.
// Runs Detect.Quiet, fires TxDetectRx_Loopback with lanes in P1, gathers
// per-lane PhyStatus/RxStatus with a timeout and reports the detected mask.
// Optional feature macro: RXDET_SECOND_PASS_EN (two-pass detection; final
// mask is the AND of both passes). Undefined: single pass.
module pipe_rx_detect_seq #(
  parameter int unsigned LANESNUMBER  = 16,
  parameter int unsigned QUIET_CYCLES = 1024,
  parameter int unsigned RESP_TIMEOUT = 256,
  parameter int unsigned RETRY_CYCLES = 1024
) (
  input  logic                       pclk,
  input  logic                       reset_n,
  input  logic                       start,
  input  logic                       abort,
  input  logic [LANESNUMBER-1:0]     PhyStatus,
  input  logic [3*LANESNUMBER-1:0]   RxStatus,
  output logic [LANESNUMBER-1:0]     TxDetectRx_Loopback,
  output logic [LANESNUMBER-1:0]     TxElecIdle,
  output logic [4*LANESNUMBER-1:0]   PowerDown,
  output logic [LANESNUMBER-1:0]     detected_lanes,
  output logic [4:0]                 NumberDetectLanes,
  output logic                       WriteDetectLanesFlag,
  output logic                       TXFinishFlag,
  output logic                       resp_timeout,
  output logic                       busy
);

  localparam int unsigned MAX_QR = (QUIET_CYCLES > RETRY_CYCLES) ? QUIET_CYCLES : RETRY_CYCLES;
  localparam int unsigned MAXC   = (MAX_QR > RESP_TIMEOUT) ? MAX_QR : RESP_TIMEOUT;
  localparam int unsigned CW     = $clog2(MAXC + 1);

`ifdef RXDET_SECOND_PASS_EN
  typedef enum logic [2:0] {IDLE, QUIET, DETECT, EVAL, RETRY_WAIT, DONE} state_t;
`else
  typedef enum logic [2:0] {IDLE, QUIET, DETECT, EVAL, DONE} state_t;
`endif

  state_t                  state_q, state_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [LANESNUMBER-1:0]  responded_q, responded_d;
  logic [LANESNUMBER-1:0]  present_q, present_d;
  logic [LANESNUMBER-1:0]  det_q, det_d;
  logic [4:0]              num_q, num_d;
  logic                    flag_q, flag_d;
  logic                    timeout_q, timeout_d;
  logic                    busy_q, busy_d;
  logic                    txdet_q, txdet_d;
  logic [LANESNUMBER-1:0]  rx_ok;
  logic [LANESNUMBER-1:0]  final_mask;
`ifdef RXDET_SECOND_PASS_EN
  logic [LANESNUMBER-1:0]  pass1_q, pass1_d;
  logic                    second_q, second_d;
`endif

  function automatic logic [4:0] popcnt(input logic [LANESNUMBER-1:0] v);
    logic [4:0] c;
    c = '0;
    for (int unsigned i = 0; i < LANESNUMBER; i++) c = c + 5'(v[i]);
    return c;
  endfunction

  // Per-lane "receiver present" decode of RxStatus.
  always_comb begin
    rx_ok = '0;
    for (int unsigned i = 0; i < LANESNUMBER; i++) rx_ok[i] = (RxStatus[3*i +: 3] == 3'b011);
  end

  // Next-state and registered-output computation.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    responded_d = responded_q;
    present_d   = present_q;
    det_d       = det_q;
    num_d       = num_q;
    flag_d      = 1'b0;
    timeout_d   = timeout_q;
    final_mask  = present_q;
`ifdef RXDET_SECOND_PASS_EN
    pass1_d     = pass1_q;
    second_d    = second_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d     = QUIET;
          cnt_d       = '0;
          responded_d = '0;
          present_d   = '0;
          timeout_d   = 1'b0;
          det_d       = '0;
          num_d       = '0;
`ifdef RXDET_SECOND_PASS_EN
          second_d    = 1'b0;
`endif
        end
      end
      QUIET: begin
        if (cnt_q == CW'(QUIET_CYCLES - 1)) begin
          state_d     = DETECT;
          cnt_d       = '0;
          responded_d = '0;
          present_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DETECT: begin
        // Only the first PhyStatus per lane captures RxStatus.
        responded_d = responded_q | PhyStatus;
        present_d   = present_q | (PhyStatus & ~responded_q & rx_ok);
        if (&responded_d) begin
          state_d = EVAL;
          cnt_d   = '0;
        end else if (cnt_q == CW'(RESP_TIMEOUT - 1)) begin
          state_d   = EVAL;
          cnt_d     = '0;
          timeout_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      EVAL: begin
        cnt_d = '0;
        if (present_q == '0) begin
          state_d = QUIET;
`ifdef RXDET_SECOND_PASS_EN
          second_d = 1'b0;
        end else if (!second_q) begin
          pass1_d  = present_q;
          second_d = 1'b1;
          state_d  = RETRY_WAIT;
        end else begin
          final_mask = pass1_q & present_q;
          second_d   = 1'b0;
          if (final_mask == '0) begin
            state_d = QUIET;
          end else begin
            state_d = DONE;
            det_d   = final_mask;
            num_d   = popcnt(final_mask);
            flag_d  = 1'b1;
          end
`else
        end else begin
          state_d = DONE;
          det_d   = final_mask;
          num_d   = popcnt(final_mask);
          flag_d  = 1'b1;
`endif
        end
      end
`ifdef RXDET_SECOND_PASS_EN
      RETRY_WAIT: begin
        if (cnt_q == CW'(RETRY_CYCLES - 1)) begin
          state_d     = DETECT;
          cnt_d       = '0;
          responded_d = '0;
          present_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
`endif
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Abort overrides everything above: no capture, no result update, no pulse.
    if (abort) begin
      state_d     = IDLE;
      cnt_d       = cnt_q;
      responded_d = responded_q;
      present_d   = present_q;
      det_d       = det_q;
      num_d       = num_q;
      flag_d      = 1'b0;
      timeout_d   = timeout_q;
`ifdef RXDET_SECOND_PASS_EN
      pass1_d     = pass1_q;
      second_d    = second_q;
`endif
    end
    busy_d  = (state_d != IDLE);
    txdet_d = (state_d == DETECT);
  end

  // State and output registers.
  always_ff @(posedge pclk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      responded_q <= '0;
      present_q   <= '0;
      det_q       <= '0;
      num_q       <= '0;
      flag_q      <= 1'b0;
      timeout_q   <= 1'b0;
      busy_q      <= 1'b0;
      txdet_q     <= 1'b0;
`ifdef RXDET_SECOND_PASS_EN
      pass1_q     <= '0;
      second_q    <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      responded_q <= responded_d;
      present_q   <= present_d;
      det_q       <= det_d;
      num_q       <= num_d;
      flag_q      <= flag_d;
      timeout_q   <= timeout_d;
      busy_q      <= busy_d;
      txdet_q     <= txdet_d;
`ifdef RXDET_SECOND_PASS_EN
      pass1_q     <= pass1_d;
      second_q    <= second_d;
`endif
    end
  end

  assign TxDetectRx_Loopback  = {LANESNUMBER{txdet_q}};
  assign TxElecIdle           = '1;
  assign PowerDown            = {LANESNUMBER{4'b0010}};
  assign detected_lanes       = det_q;
  assign NumberDetectLanes    = num_q;
  assign WriteDetectLanesFlag = flag_q;
  assign TXFinishFlag         = flag_q;
  assign resp_timeout         = timeout_q;
  assign busy                 = busy_q;

endmodule

// File: tb/tb_pipe_rx_detect_seq.sv
// Self-checking bench for pipe_rx_detect_seq (16 lanes, short timings).
module tb_pipe_rx_detect_seq;
  localparam int L = 16;
  localparam int Q = 4;
  localparam int T = 16;
  localparam int R = 8;

  logic          pclk = 1'b0;
  logic          reset_n, start, abort;
  logic [L-1:0]  PhyStatus;
  logic [3*L-1:0] RxStatus;
  logic [L-1:0]  TxDetectRx_Loopback, TxElecIdle, detected_lanes;
  logic [4*L-1:0] PowerDown;
  logic [4:0]    NumberDetectLanes;
  logic          WriteDetectLanesFlag, TXFinishFlag, resp_timeout, busy;

  pipe_rx_detect_seq #(
    .LANESNUMBER(L), .QUIET_CYCLES(Q), .RESP_TIMEOUT(T), .RETRY_CYCLES(R)
  ) dut (
    .pclk(pclk), .reset_n(reset_n), .start(start), .abort(abort),
    .PhyStatus(PhyStatus), .RxStatus(RxStatus),
    .TxDetectRx_Loopback(TxDetectRx_Loopback), .TxElecIdle(TxElecIdle),
    .PowerDown(PowerDown), .detected_lanes(detected_lanes),
    .NumberDetectLanes(NumberDetectLanes),
    .WriteDetectLanesFlag(WriteDetectLanesFlag), .TXFinishFlag(TXFinishFlag),
    .resp_timeout(resp_timeout), .busy(busy)
  );

  always #5 pclk = ~pclk;

  typedef struct packed {
    logic [15:0] mask;
    logic [4:0]  num;
    logic        to;
  } exp_t;

  exp_t sb[$];
  int vecs = 0;
  int errs = 0;
  int wr_cnt = 0;

  always @(posedge pclk) if (WriteDetectLanesFlag === 1'b1) wr_cnt++;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_start();
    start = 1'b1;
    @(negedge pclk);
    start = 1'b0;
    chk("busy_after_start", 64'(busy), 64'd1);
  endtask

  // Answers one detect pass: lane i responds at offset (i % spread) after
  // Loopback is seen high, if resp[i]. Returns cycles waited and held.
  task automatic do_detect(input logic [15:0] resp, input logic [15:0] pres,
                           input int spread, output int waited, output int hold);
    for (int i = 0; i < L; i++) RxStatus[3*i +: 3] = pres[i] ? 3'b011 : 3'b000;
    waited = 0;
    while (TxDetectRx_Loopback[0] !== 1'b1 && waited < 100) begin
      waited++;
      @(negedge pclk);
    end
    chk("loopback_all_lanes", 64'(TxDetectRx_Loopback), 64'hFFFF);
    hold = 0;
    while (TxDetectRx_Loopback[0] === 1'b1 && hold < 100) begin
      for (int i = 0; i < L; i++) PhyStatus[i] = resp[i] && ((i % spread) == hold);
      hold++;
      @(negedge pclk);
    end
    PhyStatus = '0;
  endtask

  task automatic wait_result();
    int n;
    exp_t e;
    e = '0;
    n = 0;
    while (WriteDetectLanesFlag !== 1'b1 && n < 200) begin
      n++;
      @(negedge pclk);
    end
    if (sb.size() > 0) e = sb.pop_front();
    chk("write_pulse", 64'(WriteDetectLanesFlag), 64'd1);
    chk("finish_pulse", 64'(TXFinishFlag), 64'd1);
    chk("detected_lanes", 64'(detected_lanes), 64'(e.mask));
    chk("num_lanes", 64'(NumberDetectLanes), 64'(e.num));
    chk("resp_timeout", 64'(resp_timeout), 64'(e.to));
    @(negedge pclk);
    chk("write_single", 64'(WriteDetectLanesFlag), 64'd0);
    chk("finish_single", 64'(TXFinishFlag), 64'd0);
    chk("idle_after_done", 64'(busy), 64'd0);
    chk("detected_hold", 64'(detected_lanes), 64'(e.mask));
  endtask

  initial begin
    int w, h, wr0;
    reset_n = 1'b0; start = 1'b0; abort = 1'b0;
    PhyStatus = '0; RxStatus = '0;
    repeat (3) @(negedge pclk);
    // Reset state
    chk("rst_loopback", 64'(TxDetectRx_Loopback), 64'h0);
    chk("rst_elecidle", 64'(TxElecIdle), 64'hFFFF);
    chk("rst_powerdown", PowerDown, {16{4'b0010}});
    chk("rst_detected", 64'(detected_lanes), 64'h0);
    chk("rst_num", 64'(NumberDetectLanes), 64'h0);
    chk("rst_write", 64'(WriteDetectLanesFlag), 64'h0);
    chk("rst_finish", 64'(TXFinishFlag), 64'h0);
    chk("rst_timeout", 64'(resp_timeout), 64'h0);
    chk("rst_busy", 64'(busy), 64'h0);
    reset_n = 1'b1;
    repeat (5) @(negedge pclk);
    chk("idle_no_start", 64'(busy), 64'h0);

    // All 16 lanes present
    sb.push_back('{16'hFFFF, 5'd16, 1'b0});
    do_start();
    do_detect(16'hFFFF, 16'hFFFF, 1, w, h);
    chk("quiet_len", 64'(w), 64'(Q));
    chk("all_hold", 64'(h), 64'd1);
    chk("p1_busy", PowerDown, {16{4'b0010}});
`ifdef RXDET_SECOND_PASS_EN
    do_detect(16'hFFFF, 16'hFFFF, 1, w, h);
    chk("retry_len", 64'(w), 64'(R + 1));
`endif
    wait_result();

    // Staggered partial response over 10 cycles, lanes 0-3 present
    sb.push_back('{16'h000F, 5'd4, 1'b0});
    do_start();
    do_detect(16'hFFFF, 16'h000F, 10, w, h);
    chk("stagger_hold", 64'(h), 64'd10);
`ifdef RXDET_SECOND_PASS_EN
    do_detect(16'hFFFF, 16'h000F, 10, w, h);
`endif
    wait_result();

    // None present: loops back to QUIET, then abort
    wr0 = wr_cnt;
    do_start();
    do_detect(16'hFFFF, 16'h0000, 1, w, h);
    do_detect(16'hFFFF, 16'h0000, 1, w, h);
    chk("requiet_len", 64'(w), 64'(Q + 1));
    chk("none_busy", 64'(busy), 64'd1);
    abort = 1'b1;
    @(negedge pclk);
    abort = 1'b0;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_loopback", 64'(TxDetectRx_Loopback), 64'h0);
    repeat (Q + 3) @(negedge pclk);
    chk("abort_stays_idle", 64'(TxDetectRx_Loopback), 64'h0);
    chk("none_no_write", 64'(wr_cnt), 64'(wr0));

    // Timeout: lanes 8-15 silent, lanes 0-7 present
    sb.push_back('{16'h00FF, 5'd8, 1'b1});
    do_start();
    do_detect(16'h00FF, 16'h00FF, 1, w, h);
    chk("timeout_hold", 64'(h), 64'(T));
`ifdef RXDET_SECOND_PASS_EN
    do_detect(16'h00FF, 16'h00FF, 1, w, h);
`endif
    wait_result();

    // Pass disagreement: pass1 lanes 0-7, pass2 lanes 0-3
`ifdef RXDET_SECOND_PASS_EN
    sb.push_back('{16'h000F, 5'd4, 1'b0});
`else
    sb.push_back('{16'h00FF, 5'd8, 1'b0});
`endif
    do_start();
    do_detect(16'hFFFF, 16'h00FF, 1, w, h);
`ifdef RXDET_SECOND_PASS_EN
    do_detect(16'hFFFF, 16'h000F, 1, w, h);
`endif
    wait_result();

    // Start while busy ignored, then asynchronous reset mid-operation
    do_start();
    start = 1'b1;
    @(negedge pclk);
    start = 1'b0;
    chk("start_busy_ignored", 64'(TxDetectRx_Loopback), 64'h0);
    #2 reset_n = 1'b0;
    #1;
    chk("async_rst_busy", 64'(busy), 64'd0);
    chk("async_rst_detected", 64'(detected_lanes), 64'h0);
    chk("async_rst_num", 64'(NumberDetectLanes), 64'h0);
    @(negedge pclk);
    reset_n = 1'b1;
    repeat (2) @(negedge pclk);
    chk("sb_drained", 64'(sb.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
